ray_nearest_hit: RTL and testbench

Per-ray object sequencer and closest-hit resolver. It sits downstream of the pixel ray generator and wraps the combinational sphere intersection stage. For each accepted ray it walks the object table, presents one object at a time to the sphere tracer alongside the latched ray, and keeps the smallest returned t. It then emits the winning object's colour, or the background colour, to the framebuffer writer.

---
 rtl/ray_nearest_hit_if.sv | 33 +++
 rtl/ray_nearest_hit.sv | 110 +++++++++++
 tb/tb_ray_nearest_hit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ray_nearest_hit_if.sv
// Ray/tracer/object-table/pixel bus for the closest-hit sequencer.
// The slave side is the sequencer; the master side is its surrounding pipeline.
interface ray_nearest_hit_if #(
   parameter int OBJ_AW = 3
);
   logic              ray_valid;
   logic              ray_ready;
   logic [27:0]       ray_init;
   logic [30:0]       ray_dir;
   logic [27:0]       tr_init;
   logic [30:0]       tr_dir;
   logic [47:0]       tr_obj;
   logic [9:0]        tr_t;
   logic [OBJ_AW-1:0] obj_addr;
   logic [47:0]       obj_data;
   logic              pix_valid;
   logic              pix_ready;
   logic [11:0]       pix_color;
   logic [9:0]        pix_t;
   logic              pix_hit;

   modport slave (
      input  ray_valid, ray_init, ray_dir, tr_t, obj_data, pix_ready,
      output ray_ready, tr_init, tr_dir, tr_obj, obj_addr,
             pix_valid, pix_color, pix_t, pix_hit
   );

   modport master (
      output ray_valid, ray_init, ray_dir, tr_t, obj_data, pix_ready,
      input  ray_ready, tr_init, tr_dir, tr_obj, obj_addr,
             pix_valid, pix_color, pix_t, pix_hit
   );
endinterface

// File: rtl/ray_nearest_hit.sv
// Walks the object table for each accepted ray, feeds each object to the sphere
// tracer and keeps the nearest hit, then hands the winning colour downstream.
module ray_nearest_hit #(
   parameter int          OBJ_COUNT = 8,
   parameter int          OBJ_AW    = 3,
   parameter logic [11:0] BG_COLOR  = 12'h000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   ray_nearest_hit_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_EVAL  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   logic [OBJ_AW-1:0] r_idx;
   logic [27:0]       r_tr_init;
   logic [30:0]       r_tr_dir;
   logic [47:0]       r_tr_obj;
   logic [9:0]        r_best_t;
   logic [11:0]       r_best_color;
   logic              r_best_hit;
   logic              r_ray_ready;
   logic              r_pix_valid;

   logic              w_candidate;
   logic              w_last;

   // Zero radius marks an empty slot; strict compare keeps the lower index on ties.
   assign w_candidate = (r_tr_obj[35:28] != 8'd0) && (bus.tr_t != 10'h3FF) &&
                        (bus.tr_t < r_best_t);
   assign w_last      = (r_idx == OBJ_AW'(OBJ_COUNT - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= {OBJ_AW{1'b0}};
         r_tr_init    <= 28'd0;
         r_tr_dir     <= 31'd0;
         r_tr_obj     <= 48'd0;
         r_best_t     <= 10'h3FF;
         r_best_color <= BG_COLOR;
         r_best_hit   <= 1'b0;
         r_ray_ready  <= 1'b1;
         r_pix_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.ray_valid) begin
                  r_tr_init    <= bus.ray_init;
                  r_tr_dir     <= bus.ray_dir;
                  r_idx        <= {OBJ_AW{1'b0}};
                  r_best_t     <= 10'h3FF;
                  r_best_color <= BG_COLOR;
                  r_best_hit   <= 1'b0;
                  r_ray_ready  <= 1'b0;
                  r_state      <= S_FETCH;
               end
            end
            // r_idx doubles as the ROM address, so it is already presented in FETCH.
            S_FETCH: r_state <= S_LOAD;
            S_LOAD: begin
               r_tr_obj <= bus.obj_data;
               r_state  <= S_EVAL;
            end
            S_EVAL: begin
               if (w_candidate) begin
                  r_best_t     <= bus.tr_t;
                  r_best_color <= r_tr_obj[47:36];
                  r_best_hit   <= 1'b1;
               end
               if (w_last) begin
                  r_pix_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx   <= r_idx + OBJ_AW'(1);
                  r_state <= S_FETCH;
               end
            end
            S_DONE: begin
               if (bus.pix_ready) begin
                  r_pix_valid <= 1'b0;
                  r_ray_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_pix_valid <= 1'b0;
               r_ray_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ray_ready = r_ray_ready;
   assign bus.tr_init   = r_tr_init;
   assign bus.tr_dir    = r_tr_dir;
   assign bus.tr_obj    = r_tr_obj;
   assign bus.obj_addr  = r_idx;
   assign bus.pix_valid = r_pix_valid;
   assign bus.pix_color = r_best_color;
   assign bus.pix_t     = r_best_t;
   assign bus.pix_hit   = r_best_hit;
endmodule

// File: tb/tb_ray_nearest_hit.sv
// Directed bench for ray_nearest_hit: per-ray object tables with hand-computed
// nearest hits, plus backpressure and mid-scan reset sequences.
module tb_ray_nearest_hit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ray_nearest_hit_if #(.OBJ_AW(3)) bus ();

   ray_nearest_hit #(.OBJ_COUNT(8), .OBJ_AW(3), .BG_COLOR(12'h000)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [7:0][9:0]  t;
      logic [7:0][11:0] color;
      logic [7:0][7:0]  r;
      logic [9:0]       exp_t;
      logic [11:0]      exp_color;
      logic             exp_hit;
   } vec_t;

   vec_t       vecs [5];
   logic [47:0] rom [8];
   logic [9:0]  trt_tab [8];
   int          n_checks = 0;
   int          n_errors = 0;

   // Object table: synchronous ROM; centre field carries the object index.
   always @(posedge clk) bus.obj_data <= rom[bus.obj_addr];
   // Tracer model: t looked up by object index, deliberately ignoring radius.
   always_comb bus.tr_t = trt_tab[bus.tr_obj[2:0]];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_vec(input int v);
      for (int j = 0; j < 8; j++) begin
         rom[j]     = {vecs[v].color[j], vecs[v].r[j], 28'(j)};
         trt_tab[j] = vecs[v].t[j];
      end
   endtask

   task automatic check_reset_state();
      chk("rst_ray_ready", 64'(bus.ray_ready), 64'd1);
      chk("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
      chk("rst_pix_color", 64'(bus.pix_color), 64'h000);
      chk("rst_pix_t",     64'(bus.pix_t),     64'h3FF);
      chk("rst_pix_hit",   64'(bus.pix_hit),   64'd0);
      chk("rst_tr_init",   64'(bus.tr_init),   64'd0);
      chk("rst_tr_dir",    64'(bus.tr_dir),    64'd0);
      chk("rst_tr_obj",    64'(bus.tr_obj),    64'd0);
      chk("rst_obj_addr",  64'(bus.obj_addr),  64'd0);
   endtask

   task automatic send_ray(input logic [27:0] init, input logic [30:0] dir);
      int n;
      n = 0;
      @(negedge clk);
      bus.ray_init  = init;
      bus.ray_dir   = dir;
      bus.ray_valid = 1'b1;
      while (!bus.ray_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 64'(n < 50), 64'd1);
      @(posedge clk);
      #1;
      bus.ray_valid = 1'b0;
      chk("tr_init_latched", 64'(bus.tr_init), 64'(init));
      chk("tr_dir_latched",  64'(bus.tr_dir),  64'(dir));
   endtask

   // Called #1 after the acceptance edge; pix_valid must rise after edge 24 (cycle 25).
   task automatic wait_pix_and_check(input int v);
      int lat;
      lat = 0;
      while (!bus.pix_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("pix_latency", 64'(lat), 64'd24);
      chk("pix_t",       64'(bus.pix_t),     64'(vecs[v].exp_t));
      chk("pix_color",   64'(bus.pix_color), 64'(vecs[v].exp_color));
      chk("pix_hit",     64'(bus.pix_hit),   64'(vecs[v].exp_hit));
   endtask

   task automatic release_pix();
      @(negedge clk);
      bus.pix_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_pix_valid", 64'(bus.pix_valid), 64'd0);
      chk("release_ray_ready", 64'(bus.ray_ready), 64'd1);
      @(negedge clk);
      bus.pix_ready = 1'b0;
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 5; i++) begin
         vecs[i].t     = {8{10'h3FF}};
         vecs[i].color = {8{12'h777}};
         vecs[i].r     = {8{8'd10}};
      end
      // All miss
      vecs[0].exp_t = 10'h3FF; vecs[0].exp_color = 12'h000; vecs[0].exp_hit = 1'b0;
      // Two hits, nearer one wins
      vecs[1].t[2] = 10'd120; vecs[1].color[2] = 12'hF00;
      vecs[1].t[5] = 10'd45;  vecs[1].color[5] = 12'h0F0;
      vecs[1].exp_t = 10'd45; vecs[1].exp_color = 12'h0F0; vecs[1].exp_hit = 1'b1;
      // Tie keeps lower index
      vecs[2].t[1] = 10'd77; vecs[2].color[1] = 12'h00F;
      vecs[2].t[6] = 10'd77; vecs[2].color[6] = 12'hFFF;
      vecs[2].exp_t = 10'd77; vecs[2].exp_color = 12'h00F; vecs[2].exp_hit = 1'b1;
      // Empty slot (r=0) must be ignored even with small t
      vecs[3].t[3] = 10'd5;   vecs[3].color[3] = 12'h123; vecs[3].r[3] = 8'd0;
      vecs[3].t[4] = 10'd200; vecs[3].color[4] = 12'hABC;
      vecs[3].exp_t = 10'd200; vecs[3].exp_color = 12'hABC; vecs[3].exp_hit = 1'b1;
      // t=0 on the last object beats an earlier hit
      vecs[4].t[0] = 10'd10; vecs[4].color[0] = 12'h111;
      vecs[4].t[7] = 10'd0;  vecs[4].color[7] = 12'h5A5;
      vecs[4].exp_t = 10'd0; vecs[4].exp_color = 12'h5A5; vecs[4].exp_hit = 1'b1;

      rst_n = 1'b0;
      bus.ray_valid = 1'b0;
      bus.ray_init  = 28'd0;
      bus.ray_dir   = 31'd0;
      bus.pix_ready = 1'b0;
      load_vec(0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         load_vec(v);
         send_ray(28'h1234560 + 28'(v), 31'h2ABCDE0 + 31'(v));
         wait_pix_and_check(v);
         release_pix();
      end

      // Backpressure: hold DONE for 10 cycles while a new ray is offered
      load_vec(1);
      send_ray(28'h0AAAAAA, 31'h0555555);
      wait_pix_and_check(1);
      @(negedge clk);
      bus.ray_init  = 28'h0BBBBBB;
      bus.ray_dir   = 31'h0666666;
      bus.ray_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("bp_pix_valid", 64'(bus.pix_valid), 64'd1);
         chk("bp_ray_ready", 64'(bus.ray_ready), 64'd0);
         chk("bp_pix_color", 64'(bus.pix_color), 64'h0F0);
         chk("bp_pix_t",     64'(bus.pix_t),     64'd45);
         chk("bp_tr_init",   64'(bus.tr_init),   64'h0AAAAAA);
      end
      release_pix();
      @(posedge clk);
      #1;
      bus.ray_valid = 1'b0;
      chk("bp_new_accept", 64'(bus.ray_ready), 64'd0);
      chk("bp_new_init",   64'(bus.tr_init),   64'h0BBBBBB);
      chk("bp_new_dir",    64'(bus.tr_dir),    64'h0666666);
      wait_pix_and_check(1);
      release_pix();

      // Reset during EVAL of object 4 (cycle 15), then a clean rescan
      load_vec(3);
      send_ray(28'h0C0FFEE, 31'h0BEEF00);
      repeat (14) @(posedge clk);
      #1;
      chk("eval4_obj", 64'(bus.tr_obj[2:0]), 64'd4);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_state();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (bus.pix_valid) seen++;
      end
      chk("rst_no_result", 64'(seen), 64'd0);
      load_vec(2);
      send_ray(28'h0123456, 31'h0654321);
      wait_pix_and_check(2);
      release_pix();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
